// File: rtl/synch_memory_arb.sv
// synch_memory_arb: arbitrates two requesters onto one synchronous single-port memory.
// Define SYNCH_MEMORY_ARB_RR_EN for round-robin arbitration; otherwise requester a has fixed priority.
module synch_memory_arb #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1    // legal range 1..3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              done_a,
    output logic              done_b,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_enable,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_address,
    inout  wire  [DATA_W-1:0] mem_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    logic              lat_b;       // granted requester: 0 = a, 1 = b
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic [1:0]        wait_cnt;

    logic              grant_b;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef SYNCH_MEMORY_ARB_RR_EN
    logic              rr_b_next;   // 1 = b wins the next tie
`endif

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        grant_b = 1'b0;
`ifdef SYNCH_MEMORY_ARB_RR_EN
        if (req_a && req_b)
            grant_b = rr_b_next;
        else
            grant_b = req_b;
`else
        grant_b = req_b && !req_a;
`endif
        sel_we    = grant_b ? we_b    : we_a;
        sel_addr  = grant_b ? addr_b  : addr_a;
        sel_wdata = grant_b ? wdata_b : wdata_a;
    end

    // The block owns the bus only for the single write ACCESS cycle.
    assign mem_data = (state == ACCESS && lat_we) ? lat_wdata : {DATA_W{1'bz}};

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done_a      <= 1'b0;
            done_b      <= 1'b0;
            mem_enable  <= 1'b0;
            mem_we      <= 1'b0;
            mem_address <= '0;
            rdata       <= '0;
            lat_b       <= 1'b0;
            lat_we      <= 1'b0;
            lat_wdata   <= '0;
            wait_cnt    <= '0;
`ifdef SYNCH_MEMORY_ARB_RR_EN
            rr_b_next   <= 1'b0;
`endif
        end else begin
            done_a <= 1'b0;
            done_b <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        state       <= ACCESS;
                        busy        <= 1'b1;
                        lat_b       <= grant_b;
                        lat_we      <= sel_we;
                        lat_wdata   <= sel_wdata;
                        mem_enable  <= 1'b1;
                        mem_we      <= sel_we;
                        mem_address <= sel_addr;
`ifdef SYNCH_MEMORY_ARB_RR_EN
                        rr_b_next   <= !grant_b;
`endif
                    end
                end
                ACCESS: begin
                    mem_enable <= 1'b0;
                    mem_we     <= 1'b0;
                    if (lat_we) begin
                        state  <= DONE;
                        done_a <= !lat_b;
                        done_b <= lat_b;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= 2'(RD_LAT - 1);
                    end
                end
                WAIT: begin
                    // Final WAIT edge: the memory has had RD_LAT clocks to present data.
                    if (wait_cnt == 2'd0) begin
                        rdata  <= mem_data;
                        state  <= DONE;
                        done_a <= !lat_b;
                        done_b <= lat_b;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_synch_memory_arb.sv
// Self-checking bench for synch_memory_arb: vector table, hand sequences and random traffic
// checked against a transaction-level model; a second instance exercises RD_LAT=3.
`timescale 1ns/1ps
module tb_synch_memory_arb;

    typedef struct {
        bit         ra;
        bit         rb;
        bit         wa;
        bit         wb;
        logic [3:0] aa;
        logic [3:0] ab;
        logic [7:0] da;
        logic [7:0] db;
        bit         exp_b;
        int         exp_lat;
        logic [7:0] exp_rdata;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic       req_a3 = 1'b0, req_b3 = 1'b0;
    logic [3:0] addr_a = '0, addr_b = '0;
    logic [7:0] wdata_a = '0, wdata_b = '0;

    logic       done_a, done_b, busy, mem_enable, mem_we;
    logic [7:0] rdata;
    logic [3:0] mem_address;
    tri1  [7:0] mem_data;   // an undriven bus reads as 8'hFF

    logic       done_a3, done_b3, busy3, mem_enable3, mem_we3;
    logic [7:0] rdata3;
    logic [3:0] mem_address3;
    tri1  [7:0] mem_data3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    synch_memory_arb #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .done_a(done_a), .done_b(done_b), .rdata(rdata), .busy(busy),
        .mem_enable(mem_enable), .mem_we(mem_we), .mem_address(mem_address),
        .mem_data(mem_data)
    );

    synch_memory_arb #(.ADDR_W(4), .DATA_W(8), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_a(req_a3), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .req_b(req_b3), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .done_a(done_a3), .done_b(done_b3), .rdata(rdata3), .busy(busy3),
        .mem_enable(mem_enable3), .mem_we(mem_we3), .mem_address(mem_address3),
        .mem_data(mem_data3)
    );

    function automatic logic [7:0] init_val(int i);
        return 8'(i * 29 + 7);
    endfunction

    // Synchronous memories: one with 1-clock read latency, one with 3.
    logic       mem_ready = 1'b0;
    logic [7:0] mem1 [16];
    logic [7:0] mem3 [16];
    logic       rv1;
    logic [7:0] rd1;
    logic [2:0] rv3;
    logic [7:0] rd3 [3];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 16; i++) begin
                mem1[i] <= init_val(i);
                mem3[i] <= (i == 1) ? 8'h02 : init_val(i);
            end
            mem_ready <= 1'b1;
        end else begin
            if (mem_enable && mem_we)   mem1[mem_address]  <= mem_data;
            if (mem_enable3 && mem_we3) mem3[mem_address3] <= mem_data3;
        end
        rv1    <= mem_enable && !mem_we;
        rd1    <= mem1[mem_address];
        rv3    <= {rv3[1:0], mem_enable3 && !mem_we3};
        rd3[0] <= mem3[mem_address3];
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end

    assign mem_data  = (rv1 && !reset)    ? rd1    : 8'bz;
    assign mem_data3 = (rv3[2] && !reset) ? rd3[2] : 8'bz;

    // Transaction-level reference model.
    logic [7:0] m_mem [16];
    logic [7:0] m_last_rd;
`ifdef SYNCH_MEMORY_ARB_RR_EN
    bit         m_ptr_b;
`endif

    function automatic vec_t predict(input vec_t v);
        vec_t r;
        bit   win_b;
        r = v;
`ifdef SYNCH_MEMORY_ARB_RR_EN
        win_b   = (v.ra && v.rb) ? m_ptr_b : v.rb;
        m_ptr_b = !win_b;
`else
        win_b = !v.ra;
`endif
        r.exp_b = win_b;
        if (win_b ? v.wb : v.wa) begin
            m_mem[win_b ? v.ab : v.aa] = win_b ? v.db : v.da;
            r.exp_lat = 2;
        end else begin
            m_last_rd = m_mem[win_b ? v.ab : v.aa];
            r.exp_lat = 2 + 1;
        end
        r.exp_rdata = m_last_rd;
        return r;
    endfunction

    function automatic vec_t mk(bit ra, bit rb, bit wa, bit wb, logic [3:0] aa, logic [3:0] ab,
                                logic [7:0] da, logic [7:0] db, bit eb, int el, logic [7:0] er);
        vec_t v;
        v.ra = ra; v.rb = rb; v.wa = wa; v.wb = wb;
        v.aa = aa; v.ab = ab; v.da = da; v.db = db;
        v.exp_b = eb; v.exp_lat = el; v.exp_rdata = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, expected event never seen", name);
    endtask

    task automatic wait_idle(input string name);
        int n;
        @(negedge clk);
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) timeout(name);
    endtask

    // Drives one single-shot request pair from IDLE and checks the full access.
    task automatic run_vec(input vec_t v, input string tag);
        int         n;
        bit         ew;
        logic [3:0] ea;
        logic [7:0] ed;
        ew = v.exp_b ? v.wb : v.wa;
        ea = v.exp_b ? v.ab : v.aa;
        ed = v.exp_b ? v.db : v.da;
        wait_idle({tag, "_idle"});
        check({tag, "_bus_idle"}, 32'(mem_data), 32'hFF);
        req_a = v.ra; we_a = v.wa; addr_a = v.aa; wdata_a = v.da;
        req_b = v.rb; we_b = v.wb; addr_b = v.ab; wdata_b = v.db;
        @(posedge clk); #1;
        req_a = 1'b0;
        req_b = 1'b0;
        check({tag, "_access"}, 32'({mem_enable, mem_we, mem_address}), 32'({1'b1, ew, ea}));
        check({tag, "_bus_acc"}, 32'(mem_data), ew ? 32'(ed) : 32'hFF);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(done_a || done_b) && n < 12);
        if (!(done_a || done_b)) begin
            timeout({tag, "_done"});
            return;
        end
        // done is registered; a consumer samples it one edge later.
        check({tag, "_who"}, 32'({done_a, done_b}), v.exp_b ? 32'b01 : 32'b10);
        check({tag, "_lat"}, 32'(n + 1), 32'(v.exp_lat));
        check({tag, "_rdata"}, 32'(rdata), 32'(v.exp_rdata));
        check({tag, "_hold"}, 32'({mem_enable, mem_we, mem_address}), 32'({2'b00, ea}));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'({done_a, done_b, busy}), 32'b000);
    endtask

    initial begin
        vec_t tbl [16];
        vec_t v;
        int   n, pulses, last;

        for (int i = 0; i < 16; i++) m_mem[i] = init_val(i);
        m_last_rd = 8'h00;
`ifdef SYNCH_MEMORY_ARB_RR_EN
        m_ptr_b = 1'b0;
`endif

        tbl[0]  = mk(1, 0, 1, 0, 4'h0, 4'h0, 8'h01, 8'h00, 0, 2, 8'h00);
        tbl[1]  = mk(1, 0, 1, 0, 4'h1, 4'h0, 8'h02, 8'h00, 0, 2, 8'h00);
        tbl[2]  = mk(1, 0, 1, 0, 4'h2, 4'h0, 8'h03, 8'h00, 0, 2, 8'h00);
        tbl[3]  = mk(1, 0, 1, 0, 4'h3, 4'h0, 8'h05, 8'h00, 0, 2, 8'h00);
        tbl[4]  = mk(1, 0, 1, 0, 4'h4, 4'h0, 8'h08, 8'h00, 0, 2, 8'h00);
        tbl[5]  = mk(1, 0, 1, 0, 4'h5, 4'h0, 8'h0D, 8'h00, 0, 2, 8'h00);
        tbl[6]  = mk(0, 1, 0, 0, 4'h0, 4'h0, 8'h00, 8'h00, 1, 3, 8'h01);
        tbl[7]  = mk(0, 1, 0, 0, 4'h0, 4'h1, 8'h00, 8'h00, 1, 3, 8'h02);
        tbl[8]  = mk(0, 1, 0, 0, 4'h0, 4'h2, 8'h00, 8'h00, 1, 3, 8'h03);
        tbl[9]  = mk(0, 1, 0, 0, 4'h0, 4'h3, 8'h00, 8'h00, 1, 3, 8'h05);
        tbl[10] = mk(0, 1, 0, 0, 4'h0, 4'h4, 8'h00, 8'h00, 1, 3, 8'h08);
        tbl[11] = mk(0, 1, 0, 0, 4'h0, 4'h5, 8'h00, 8'h00, 1, 3, 8'h0D);
        tbl[12] = mk(1, 0, 1, 0, 4'hF, 4'h0, 8'hA5, 8'h00, 0, 2, 8'h0D);
        tbl[13] = mk(0, 1, 0, 0, 4'h0, 4'hF, 8'h00, 8'h00, 1, 3, 8'hA5);
        tbl[14] = mk(0, 1, 0, 1, 4'h0, 4'h9, 8'h00, 8'h5A, 1, 2, 8'hA5);
        tbl[15] = mk(1, 0, 0, 0, 4'h9, 4'h0, 8'h00, 8'h00, 0, 3, 8'h5A);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", 32'({busy, done_a, done_b, mem_enable, mem_we}), 32'h0);
        check("rst_addr_rdata", 32'({mem_address, rdata}), 32'h0);
        check("rst_bus", 32'(mem_data), 32'hFF);
        @(negedge clk);
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            v = predict(tbl[i]);
            run_vec(tbl[i], $sformatf("tbl%0d", i));
        end

        // Inputs changed during ACCESS must not reach the memory
        wait_idle("chg_idle");
        req_a = 1'b1; we_a = 1'b1; addr_a = 4'h7; wdata_a = 8'h3C;
        v = predict(mk(1, 0, 1, 0, 4'h7, 4'h0, 8'h3C, 8'h00, 0, 0, 8'h00));
        @(posedge clk); #1;
        addr_a = 4'h8; wdata_a = 8'hFF; req_a = 1'b0;
        check("chg_addr", 32'(mem_address), 32'h7);
        check("chg_bus", 32'(mem_data), 32'h3C);
        v = predict(mk(1, 0, 0, 0, 4'h7, 4'h0, 8'h00, 8'h00, 0, 0, 8'h00));
        run_vec(v, "chg_rd7");
        v = predict(mk(1, 0, 0, 0, 4'h8, 4'h0, 8'h00, 8'h00, 0, 0, 8'h00));
        run_vec(v, "chg_rd8");

        // Random traffic against the model
        for (int i = 0; i < 40; i++) begin
            v.ra = 1'($urandom_range(0, 1));
            v.rb = 1'($urandom_range(0, 1));
            if (!v.ra && !v.rb) v.rb = 1'b1;
            v.wa = 1'($urandom_range(0, 1));
            v.wb = 1'($urandom_range(0, 1));
            v.aa = 4'($urandom);
            v.ab = 4'($urandom);
            v.da = 8'($urandom);
            v.db = 8'($urandom);
            v = predict(v);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        // Reset during the WAIT of a read of address 2
        wait_idle("rst_idle");
        req_b = 1'b1; we_b = 1'b0; addr_b = 4'h2;
        @(posedge clk); #1;
        req_b = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        check("rst_mid_ctrl", 32'({busy, mem_enable, mem_we, done_a, done_b}), 32'h0);
        check("rst_mid_rdata", 32'(rdata), 32'h0);
        check("rst_mid_addr", 32'(mem_address), 32'h0);
        check("rst_mid_bus", 32'(mem_data), 32'hFF);
        pulses = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done_a || done_b) pulses++;
        end
        check("rst_mid_nodone", 32'(pulses), 32'h0);
        m_last_rd = 8'h00;
`ifdef SYNCH_MEMORY_ARB_RR_EN
        m_ptr_b = 1'b0;
`endif
        @(negedge clk);
        reset = 1'b0;
        req_a = 1'b1; we_a = 1'b1; addr_a = 4'h3; wdata_a = 8'h77;
        v = predict(mk(1, 0, 1, 0, 4'h3, 4'h0, 8'h77, 8'h00, 0, 0, 8'h00));
        @(posedge clk); #1;
        req_a = 1'b0;
        check("rst_first_grant", 32'({busy, mem_enable, mem_we}), 32'b111);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(done_a || done_b) && n < 12);
        if (!(done_a || done_b)) timeout("rst_after_done");
        else check("rst_after_who_rdata", 32'({done_a, done_b, rdata}), 32'({2'b10, 8'h00}));

        // Contention: both requests held high
        wait_idle("cont_idle");
        req_a = 1'b1; we_a = 1'b1; addr_a = 4'hA; wdata_a = 8'h11;
        req_b = 1'b1; we_b = 1'b1; addr_b = 4'hB; wdata_b = 8'h22;
        pulses = 0;
        last = 0;
        n = 0;
        while (pulses < 4 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done_a || done_b) begin
                v = predict(mk(1, 1, 1, 1, 4'hA, 4'hB, 8'h11, 8'h22, 0, 0, 8'h00));
                check($sformatf("cont_who%0d", pulses), 32'({done_a, done_b}),
                      v.exp_b ? 32'b01 : 32'b10);
                if (pulses > 0) check($sformatf("cont_gap%0d", pulses), 32'(n - last), 32'd3);
                last = n;
                pulses++;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        if (pulses < 4) timeout("cont_pulses");
        v = predict(mk(0, 1, 0, 0, 4'h0, 4'hA, 8'h00, 8'h00, 0, 0, 8'h00));
        run_vec(v, "cont_rdA");

        // RD_LAT=3 instance: read address 1 holding 8'h02
        @(negedge clk);
        n = 0;
        while (busy3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_a3 = 1'b1; we_a = 1'b0; addr_a = 4'h1;
        @(posedge clk); #1;
        req_a3 = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done_a3 && n < 15);
        if (!done_a3) begin
            timeout("lat3_done");
        end else begin
            check("lat3_lat", 32'(n + 1), 32'd5);
            check("lat3_rdata", 32'(rdata3), 32'h02);
            check("lat3_done_b", 32'(done_b3), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
